// File: rtl/simple_pkg.sv
// simple_pkg: instruction field constants, slice positions and fetch FSM
// state type shared by the fetch unit and the decoder.
package simple_pkg;

  // Major opcode (op1) values
  localparam logic [1:0] OP1_ALU = 2'b11;
  localparam logic [1:0] OP1_BR  = 2'b10;

  // Branch sub-opcode (op2) values
  localparam logic [2:0] OP2_B   = 3'b100;
  localparam logic [2:0] OP2_BCC = 3'b111;

  // ALU function (op3) value that means halt
  localparam logic [3:0] OP3_HLT = 4'b1111;

  // Field slice positions inside the 16-bit instruction word
  localparam int OP1_HI = 15;
  localparam int OP1_LO = 14;
  localparam int OP2_HI = 13;
  localparam int OP2_LO = 11;
  localparam int OP3_HI = 7;
  localparam int OP3_LO = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    VALID,
    HALTED
  } fetch_state_t;

  // HLT is an ALU-class word whose function field is all ones
  function automatic logic is_hlt(input logic [15:0] word);
    return (word[OP1_HI:OP1_LO] == OP1_ALU) && (word[OP3_HI:OP3_LO] == OP3_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: PC register plus fetch FSM feeding the decode stage over a
// valid/ready handshake. Instruction memory has a fixed one-cycle read latency.
// Optional macro INSTR_FETCH_STEP_EN selects single-step mode: every non-HLT
// accept returns to IDLE so each instruction needs its own exec pulse.
//
// state  | meaning
// IDLE   | waiting for exec after reset (or between steps in single-step mode)
// FETCH  | imem_req asserted for one cycle at pc
// WAIT   | read data returning; captured into instr at the end of this cycle
// VALID  | instr presented to decode, held until instr_ready
// HALTED | HLT accepted; waiting for exec to resume at the word after HLT
module instr_fetch
  import simple_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;

  // PC arithmetic wraps naturally at the address width
  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = pc;

  // Fetch FSM with registered handshake and memory-strobe outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exec) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          instr       <= imem_rdata;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (is_hlt(instr)) begin
              // HLT wins over any branch that execute might report
              pc     <= pc_inc;
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              pc <= redirect ? redirect_pc : pc_inc;
`ifdef INSTR_FETCH_STEP_EN
              state <= IDLE;
`else
              state    <= FETCH;
              imem_req <= 1'b1;
`endif
            end
          end
        end
        HALTED: begin
          if (exec) begin
            halted   <= 1'b0;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plus randomized fetch sequences checked against a
// transaction-level model (expected fetch address, delivered word, halt flag).
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] m_pc;
  bit          m_halted;

  instr_fetch #(.ADDR_W(16), .RESET_PC(RST_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .exec        (exec),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  // One-cycle-latency memory; garbage on the bus when no read is pending
  always @(posedge clock) imem_rdata <= imem_req ? mem[imem_addr] : 16'($urandom);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  // Called at the cycle the fetch strobe should be visible; runs one
  // instruction through to acceptance and updates the model.
  task automatic fetch_one(input int delay, input bit rd, input logic [15:0] tgt);
    logic [15:0] exp_w;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    exp_w = mem[m_pc];
    exec = 1'($urandom); redirect = 1'($urandom); redirect_pc = 16'($urandom);
    tick();
    chk("wait_req", imem_req, 0);
    chk("wait_valid", instr_valid, 0);
    exec = 1'($urandom); redirect = 1'($urandom); redirect_pc = 16'($urandom);
    tick();
    chk("valid", instr_valid, 1);
    chk("instr", instr, exp_w);
    chk("instr_pc", instr_pc, m_pc);
    for (int i = 0; i < delay; i++) begin
      exec = 1'($urandom); redirect = 1'($urandom); redirect_pc = 16'($urandom);
      tick();
      chk("hold_valid", instr_valid, 1);
      chk("hold_instr", instr, exp_w);
      chk("hold_pc", instr_pc, m_pc);
      chk("hold_noreq", imem_req, 0);
    end
    instr_ready = 1'b1; redirect = rd; redirect_pc = tgt; exec = 1'($urandom);
    tick();
    instr_ready = 1'b0; redirect = 1'b0; exec = 1'b0;
    chk("accept_valid", instr_valid, 0);
    chk("instr_kept", instr, exp_w);
    if (ref_hlt(exp_w)) begin
      m_pc = m_pc + 16'd1;
      m_halted = 1'b1;
      chk("halted", halted, 1);
      chk("hlt_noreq", imem_req, 0);
    end else begin
      m_pc = rd ? tgt : m_pc + 16'd1;
      chk("not_halted", halted, 0);
    end
  endtask

  // After an accept: when fetch has stopped, confirm it stays stopped for
  // the given number of cycles, then pulse exec to restart it.
  task automatic resume(input int idle);
`ifdef INSTR_FETCH_STEP_EN
    bit need = 1'b1;
`else
    bit need = m_halted;
`endif
    if (need) begin
      for (int i = 0; i < idle; i++) begin
        chk("idle_noreq", imem_req, 0);
        chk("idle_halted", halted, 32'(m_halted));
        tick();
      end
      chk("stopped_noreq", imem_req, 0);
      exec = 1'b1;
      tick();
      exec = 1'b0;
      chk("resume_halted", halted, 0);
      m_halted = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] tgt;
    bit          rd;

    for (int a = 0; a < 65536; a++) begin
      w = 16'($urandom);
      if (ref_hlt(w)) w[4] = 1'b0;
      mem[a] = w;
    end

    // Reset, with exec held high to show reset wins
    reset = 1'b1; exec = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    exec = 1'b1;
    tick();
    exec = 1'b0;
    reset = 1'b0;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, RST_PC);
    chk("rst_halted", halted, 0);
    m_pc = RST_PC;
    m_halted = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_exec", imem_req, 0);
    end

    exec = 1'b1;
    tick();
    exec = 1'b0;
    fetch_one(0, 1'b0, 16'h0000);      // 0xFFFF, then wrap to 0
    resume(2);
    fetch_one(5, 1'b0, 16'h0000);      // backpressure at 0
    resume(2);
    fetch_one(0, 1'b1, 16'h0005);      // 1 -> branch to 5
    resume(2);
    fetch_one(1, 1'b1, 16'h0040);      // 5 -> branch to 0x40
    resume(2);
    mem[16'h0041] = 16'hC0F0;
    fetch_one(0, 1'b0, 16'h0000);      // 0x40
    resume(2);
    fetch_one(2, 1'b1, 16'h1234);      // HLT at 0x41; branch ignored
    resume(20);
    fetch_one(0, 1'b0, 16'h0000);      // resumes at 0x42
    resume(2);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0)
        mem[m_pc] = {2'b11, 6'($urandom), 4'hF, 4'($urandom)};
      rd = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      fetch_one(int'($urandom_range(0, 3)), rd, tgt);
      resume(int'($urandom_range(0, 3)));
    end

    // Reset while a read is in flight
    chk("pre_rst_req", imem_req, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_instr", instr, 16'h0000);
    chk("midrst_instr_pc", instr_pc, RST_PC);
    chk("midrst_req", imem_req, 0);
    chk("midrst_halted", halted, 0);
    tick();
    chk("midrst_late_valid", instr_valid, 0);
    chk("midrst_late_req", imem_req, 0);
    m_pc = RST_PC;
    m_halted = 1'b0;
    exec = 1'b1;
    tick();
    exec = 1'b0;
    fetch_one(0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
